// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding bus requester feeding a small FIFO of
// {pc, instr} entries to the decoder, with redirect flush and in-flight response drop.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  output logic        mem_valid_o,
  output logic [31:0] mem_address_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_instr_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

  state_e          state_q;
  logic            mem_valid_q;
  logic [31:0]     mem_address_q;
  logic [31:0]     fetch_pc_q;
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     pc_mem_q    [DEPTH];
  logic [31:0]     instr_mem_q [DEPTH];

  logic        push, pop;
  logic [31:0] redirect_pc_al;
  logic [31:0] addr_inc;

  assign redirect_pc_al = {redirect_pc_i[31:2], 2'b00};
  assign addr_inc       = mem_address_q + 32'd4;

  assign push = (state_q == StReq) && mem_ready_i && !redirect_valid_i;
  assign pop  = out_valid_o && out_ready_i && !redirect_valid_i;

  always_comb begin
    count_d = count_q;
    if (redirect_valid_i) begin
      count_d = '0;
    end else begin
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // Bus-side FSM; mem_valid/mem_address are registered so nothing combinational reaches the bus.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= StIdle;
      mem_valid_q   <= 1'b0;
      mem_address_q <= RESET_PC;
      fetch_pc_q    <= RESET_PC;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (redirect_valid_i) begin
            fetch_pc_q <= redirect_pc_al;
          end else if (count_q < DepthC) begin
            state_q       <= StReq;
            mem_valid_q   <= 1'b1;
            mem_address_q <= fetch_pc_q;
          end
        end
        StReq: begin
          if (redirect_valid_i) begin
            fetch_pc_q <= redirect_pc_al;
            if (mem_ready_i) begin
              state_q     <= StIdle;
              mem_valid_q <= 1'b0;
            end else begin
              state_q <= StDrop;
            end
          end else if (mem_ready_i) begin
            fetch_pc_q <= addr_inc;
            if (count_d < DepthC) begin
              mem_address_q <= addr_inc;
            end else begin
              state_q     <= StIdle;
              mem_valid_q <= 1'b0;
            end
          end
        end
        StDrop: begin
          if (redirect_valid_i) begin
            fetch_pc_q <= redirect_pc_al;
          end
          if (mem_ready_i) begin
            state_q     <= StIdle;
            mem_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          mem_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (redirect_valid_i) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (push) begin
          pc_mem_q[tail_q]    <= mem_address_q;
          instr_mem_q[tail_q] <= mem_rdata_i;
          tail_q              <= next_ptr(tail_q);
        end
        if (pop) begin
          head_q <= next_ptr(head_q);
        end
      end
    end
  end

  assign mem_valid_o   = mem_valid_q;
  assign mem_address_o = mem_address_q;
  assign out_valid_o   = (count_q != '0);
  assign out_pc_o      = pc_mem_q[head_q];
  assign out_instr_o   = instr_mem_q[head_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a reference model of fetch order, redirects and dropped
// responses predicts every decoder-side entry; directed phases cover stall, drop, flush and reset.
module tb_fetch_unit;

  localparam logic [31:0] Xor = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        mem_valid, mem_ready, out_valid, out_ready, redirect_valid;
  logic [31:0] mem_address, mem_rdata, redirect_pc, out_pc, out_instr;
  logic        ready_en, stall_en;
  logic [31:0] stall_addr;

  // Bus responder: answers every request unless a specific address is being stalled.
  assign mem_ready = ready_en && !(stall_en && (mem_address == stall_addr));
  assign mem_rdata = mem_address ^ Xor;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk_i           (clk),
    .reset_ni        (reset_n),
    .mem_valid_o     (mem_valid),
    .mem_address_o   (mem_address),
    .mem_ready_i     (mem_ready),
    .mem_rdata_i     (mem_rdata),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_pc_o        (out_pc),
    .out_instr_o     (out_instr)
  );

  // Second instance exercises address wrap at the top of the space.
  logic        mem_valid1, out_valid1;
  logic [31:0] mem_address1, mem_rdata1, out_pc1, out_instr1;
  logic        one = 1'b1;
  logic        zero = 1'b0;
  logic [31:0] zero32 = 32'h0;
  assign mem_rdata1 = mem_address1 ^ Xor;

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
    .clk_i           (clk),
    .reset_ni        (reset_n),
    .mem_valid_o     (mem_valid1),
    .mem_address_o   (mem_address1),
    .mem_ready_i     (one),
    .mem_rdata_i     (mem_rdata1),
    .redirect_valid_i(zero),
    .redirect_pc_i   (zero32),
    .out_valid_o     (out_valid1),
    .out_ready_i     (one),
    .out_pc_o        (out_pc1),
    .out_instr_o     (out_instr1)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", tag, got, exp);
  endtask

  // Reference model state.
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_addr;
  logic [31:0] prev_addr;
  bit          drop_pending, prev_stall;
  int          n_out = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_pc_q.delete();
      exp_instr_q.delete();
      exp_addr     = 32'h0;
      drop_pending = 1'b0;
      prev_stall   = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("addr_hold", mem_address, prev_addr);
        check_eq("valid_hold", 32'(mem_valid), 32'd1);
      end
      if (out_valid) begin
        n_out++;
        if (exp_pc_q.size() == 0) begin
          check_eq("out_valid_unexpected", 32'(out_valid), 32'd0);
        end else begin
          check_eq("out_pc", out_pc, exp_pc_q[0]);
          check_eq("out_instr", out_instr, exp_instr_q[0]);
          if (out_ready && !redirect_valid) begin
            void'(exp_pc_q.pop_front());
            void'(exp_instr_q.pop_front());
          end
        end
      end
      if (redirect_valid) begin
        exp_pc_q.delete();
        exp_instr_q.delete();
        if (mem_valid && !mem_ready) drop_pending = 1'b1;
        else if (mem_valid && mem_ready) drop_pending = 1'b0;
        exp_addr = {redirect_pc[31:2], 2'b00};
      end else if (mem_valid && mem_ready) begin
        if (drop_pending) begin
          drop_pending = 1'b0;
        end else begin
          check_eq("fetch_addr", mem_address, exp_addr);
          exp_pc_q.push_back(exp_addr);
          exp_instr_q.push_back(exp_addr ^ Xor);
          exp_addr = exp_addr + 32'd4;
        end
      end
      prev_stall = mem_valid && !mem_ready;
      prev_addr  = mem_address;
    end
  end

  logic [31:0] seq1 [3];
  int idx1 = 0;
  initial begin
    seq1[0] = 32'hFFFF_FFF8;
    seq1[1] = 32'hFFFF_FFFC;
    seq1[2] = 32'h0000_0000;
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      idx1 = 0;
    end else if (out_valid1 && idx1 < 3) begin
      check_eq("wrap_pc", out_pc1, seq1[idx1]);
      check_eq("wrap_instr", out_instr1, seq1[idx1] ^ Xor);
      idx1++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  bit found;
  int n0;

  initial begin
    reset_n        = 1'b1;
    ready_en       = 1'b1;
    stall_en       = 1'b0;
    stall_addr     = 32'h0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #1 reset_n = 1'b0;
    tick(2);
    check_eq("rst_mem_valid", 32'(mem_valid), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_mem_address", mem_address, 32'h0);
    check_eq("rst_out_pc", out_pc, 32'h0);
    check_eq("rst_out_instr", out_instr, 32'h0);
    check_eq("rst_wrap_address", mem_address1, 32'hFFFF_FFF8);

    // Streaming: first request one cycle after release, first output one cycle later.
    reset_n = 1'b1;
    tick(1);
    check_eq("first_req_valid", 32'(mem_valid), 32'd1);
    check_eq("first_req_addr", mem_address, 32'h0);
    check_eq("first_out_early", 32'(out_valid), 32'd0);
    tick(1);
    check_eq("first_out_valid", 32'(out_valid), 32'd1);
    check_eq("first_out_pc", out_pc, 32'h0);
    n0 = n_out;
    tick(8);
    check_eq("sustain_rate", 32'(n_out - n0), 32'd8);

    // Decoder stalled: buffer fills to DEPTH, then fetch stops.
    reset_n   = 1'b0;
    out_ready = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(6);
    check_eq("full_mem_valid", 32'(mem_valid), 32'd0);
    check_eq("full_out_valid", 32'(out_valid), 32'd1);
    check_eq("full_out_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1);
      if (mem_valid && mem_address == 32'h8) found = 1'b1;
    end
    check_eq("resume_at_8", 32'(found), 32'd1);
    tick(6);

    // Redirect while the request at 8 is stalled: held, then its response dropped.
    reset_n    = 1'b0;
    stall_en   = 1'b1;
    stall_addr = 32'h8;
    tick(1);
    reset_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1);
      if (mem_valid && mem_address == 32'h8) found = 1'b1;
    end
    check_eq("stall_at_8", 32'(found), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick(1);
    redirect_valid = 1'b0;
    check_eq("drop_valid", 32'(mem_valid), 32'd1);
    check_eq("drop_addr", mem_address, 32'h8);
    check_eq("drop_flush", 32'(out_valid), 32'd0);
    tick(2);
    stall_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1);
      if (out_valid) found = 1'b1;
    end
    check_eq("after_drop_out", 32'(found), 32'd1);
    check_eq("after_drop_pc", out_pc, 32'h100);
    tick(4);

    // Redirect coinciding with a completing response and a pop.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (out_valid && mem_valid && mem_ready) found = 1'b1;
      else tick(1);
    end
    check_eq("busy_for_redirect", 32'(found), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick(1);
    redirect_valid = 1'b0;
    check_eq("flush_out_valid", 32'(out_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1);
      if (out_valid) found = 1'b1;
    end
    check_eq("redirect_out", 32'(found), 32'd1);
    check_eq("redirect_out_pc", out_pc, 32'h200);
    tick(3);

    // Asynchronous reset in the middle of a request.
    check_eq("pre_reset_busy", 32'(mem_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_mem_valid", 32'(mem_valid), 32'd0);
    check_eq("async_out_valid", 32'(out_valid), 32'd0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    check_eq("post_reset_valid", 32'(mem_valid), 32'd1);
    check_eq("post_reset_addr", mem_address, 32'h0);
    tick(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: the first fetch address after reset.
REQ-003 Parameter DEPTH, default 2, legal range 2..8: instruction buffer entries.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 mem_valid  out  1  fetch request to the instruction bus.
REQ-007 mem_address  out  32  fetch address, always word aligned.
REQ-008 mem_ready  in  1  bus completion; mem_rdata is valid in the same cycle.
REQ-009 mem_rdata  in  32  fetched instruction word.
REQ-010 redirect_valid  in  1  pipeline redirect from jump, branch, trap or mret.
REQ-011 redirect_pc  in  32  redirect target; bits [1:0] ignored and treated as 0.
REQ-012 out_valid  out  1  buffered instruction available to the decoder.
REQ-013 out_ready  in  1  decoder accepts the head entry.
REQ-014 out_pc  out  32  address of the head instruction.
REQ-015 out_instr  out  32  raw head instruction word, as consumed by the decoder.

Function
REQ-016 The FSM SHALL have three states: IDLE (no request), REQ (request whose data is kept) and DROP (request whose data is discarded).
REQ-017 mem_valid SHALL be 1 exactly when the state is REQ or DROP; it SHALL come from registers, with no combinational path from any input.
REQ-018 While mem_valid=1, mem_address SHALL hold stable until the cycle with mem_ready=1. Requests SHALL NOT be withdrawn early.
REQ-019 Only one bus request SHALL be outstanding at a time.
REQ-020 IDLE->REQ with mem_address=fetch_pc SHALL occur when redirect_valid=0 and the buffer count is below DEPTH.
REQ-021 In REQ, when mem_ready=1 and redirect_valid=0:
  - push {mem_address, mem_rdata} into the buffer;
  - set fetch_pc = mem_address + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0);
  - go to REQ again if post-push, post-pop count < DEPTH, else IDLE.
REQ-022 REQ with mem_ready=0 SHALL stay in REQ.
REQ-023 redirect_valid=1 SHALL, in the same cycle:
  - clear the buffer, with out_valid=0 from the next cycle;
  - load fetch_pc = {redirect_pc[31:2], 2'b00};
  - suppress any push or pop.
REQ-024 redirect_valid=1 in IDLE, or in REQ/DROP with mem_ready=1, SHALL go to IDLE. Fetch at the new pc SHALL start no earlier than the following cycle.
REQ-025 redirect_valid=1 in REQ with mem_ready=0 SHALL go to DROP.
REQ-026 DROP SHALL hold the old request until mem_ready=1, discard mem_rdata, then go to IDLE. A redirect during DROP SHALL only update fetch_pc.
REQ-027 The buffer SHALL be FIFO-ordered. out_valid=1 SHALL mean the buffer is not empty. out_pc and out_instr SHALL show the head entry and stay stable while out_valid=1 and out_ready=0.
REQ-028 Pop SHALL occur on out_valid and out_ready with no redirect. Push and pop in the same cycle SHALL both take effect.
REQ-029 The count SHALL never exceed DEPTH or underflow. Push is impossible when count=DEPTH because REQ-020 and REQ-021 gate issue.
REQ-030 Latency SHALL be: data accepted in cycle N is visible on out_* in cycle N+1.
REQ-031 With mem_ready held at 1 and out_ready held at 1, the block SHALL sustain one instruction per cycle.

Reset
REQ-032 Reset assertion SHALL immediately force: state=IDLE, mem_valid=0, out_valid=0, buffer count=0, fetch_pc=RESET_PC.
REQ-033 mem_address SHALL reset to RESET_PC. out_pc and out_instr SHALL reset to 0.
REQ-034 Reset mid-request SHALL abandon the request; the bus is reset together with the block.
REQ-035 In the first cycle after reset release, state SHALL go IDLE->REQ.

Verification
REQ-036 Reset release, mem_ready=1, out_ready=1, rdata=pc^32'hA5A5_0000:
  - out_* shows pc 0,4,8,... on consecutive cycles;
  - first out_valid appears 2 cycles after release.
REQ-037 out_ready=0, mem_ready=1, DEPTH=2:
  - exactly 2 entries are buffered (pc 0,4), then mem_valid=0;
  - raising out_ready drains 0 then 4, and fetching resumes at 8.
REQ-038 Redirect to 32'h0000_0103 while REQ is stalled at addr 8 (mem_ready=0):
  - state becomes DROP and addr 8 is held;
  - on ready, the data is discarded;
  - the next request is 0x100, and out_pc shows 0x100 first.
REQ-039 Redirect in the same cycle as mem_ready=1 and a pop:
  - buffer empties and the response is not pushed;
  - next out_pc = redirect target.
REQ-040 RESET_PC=32'hFFFF_FFF8, all ready:
  - out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-041 reset_n pulled low while mem_valid=1:
  - mem_valid and out_valid go 0 asynchronously, before the next clock edge;
  - after release, the first address is RESET_PC.
